// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the TX DMA fetch path.
//   tx_desc_t      - decoded descriptor (byte address, byte length, EOF flag)
//   fetch_state_e  - fetch engine states
//   AXI_RESP_OKAY, AXI_BURST_INCR, AXI_SIZE_8B - fixed AXI encodings
//   keep_mask()    - byte-keep for a trailing partial word
package dma_pkg;

  typedef struct packed {
    logic        eof;
    logic [15:0] len;
    logic [31:0] addr;
  } tx_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } fetch_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

  // Low 'lo' bytes valid; lo = 0 means the final word is full.
  function automatic logic [7:0] keep_mask(input logic [2:0] lo);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (lo == 3'd0) || (3'(i) < lo);
    end
    return m;
  endfunction

endpackage

// File: rtl/AXI_clks.sv
// AXI_clks: clock/reset bundle shared by the AXI-side blocks.
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
interface AXI_clks;
  logic clk;
  logic rst;
  modport to_rtl (input clk, input rst);
endinterface

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: combinational burst sizing for the TX fetch engine.
// Given the address and remaining byte count of the next burst, produces
// ARLEN, whether this burst finishes the descriptor, and the byte-keep of
// the descriptor's final word.
//   cur_addr   - byte address of the burst (bits [2:0] are zero)
//   bytes_left - bytes still to fetch for the descriptor (non-zero)
//   arlen      - beats - 1
//   last_burst - this burst carries the descriptor's final beat
//   keep_last  - tx_keep for the descriptor's final beat
// Build option DMA_TX_4K_SPLIT_EN: clip bursts at 4 KB address boundaries.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [31:0] cur_addr,
  input  logic [15:0] bytes_left,
  output logic [7:0]  arlen,
  output logic        last_burst,
  output logic [7:0]  keep_last
);

  localparam logic [16:0] MAX_BEATS = 17'(MAX_BURST);

  logic [16:0] beats_rem;
  logic [16:0] beats;
  logic        unused_addr;

  // ceil(bytes/8) in 17 bits so a length of 0xFFFF cannot overflow.
  assign beats_rem = ({1'b0, bytes_left} + 17'd7) >> 3;

`ifdef DMA_TX_4K_SPLIT_EN
  logic [16:0] room;

  // Words left before the next 4 KB boundary: 1..512.
  assign room        = 17'd512 - {8'd0, cur_addr[11:3]};
  assign unused_addr = ^{cur_addr[31:12], cur_addr[2:0]};

  always_comb begin
    beats = (beats_rem < MAX_BEATS) ? beats_rem : MAX_BEATS;
    if (room < beats) begin
      beats = room;
    end
  end
`else
  assign unused_addr = ^cur_addr;
  assign beats       = (beats_rem < MAX_BEATS) ? beats_rem : MAX_BEATS;
`endif

  assign arlen      = 8'(beats - 17'd1);
  assign last_burst = (beats == beats_rem);
  assign keep_last  = keep_mask(bytes_left[2:0]);

endmodule

// File: rtl/dma_tx_fetch.sv
// dma_tx_fetch: pops TX descriptors from the descriptor stack, splits each
// into AXI4 INCR read bursts (one outstanding), and streams the returned
// 64-bit words with byte-keep / end-of-frame into the TX frame buffer.
//   clks        - clock (clks.clk) and async active-low reset (clks.rst)
//   enable      - fetch permitted, sampled in IDLE only
//   haddr       - head descriptor: [31:0] addr, [47:32] len, [63] EOF
//   stack_empty - no descriptor available; rd_en pops one (1-cycle strobe)
//   ar* / r*    - AXI4 read address and data channels
//   tx_*        - frame buffer stream (single output register)
//   busy        - engine not IDLE
//   frames_done - EOF descriptors completed (wraps)
//   err         - sticky, any non-OKAY rresp; engine parks in ERR after
//                 finishing the failing descriptor
// Build option DMA_TX_4K_SPLIT_EN: bursts never cross a 4 KB boundary.
module dma_tx_fetch
  import dma_pkg::*;
#(
  parameter int         MAX_BURST = 16,
  parameter logic [3:0] AXI_ID    = 4'h0
) (
  AXI_clks.to_rtl     clks,
  input  logic        enable,
  input  logic [63:0] haddr,
  input  logic        stack_empty,
  output logic        rd_en,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_keep,
  output logic        tx_last,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frames_done,
  output logic        err
);

  tx_desc_t     desc;
  fetch_state_e state;

  logic [31:0] cur_addr;
  logic [15:0] bytes_left;
  logic        eof_r;
  logic        last_burst_r;
  logic [7:0]  keep_last_r;

  logic [8:0]  burst_beats;
  logic [31:0] nxt_addr;
  logic [15:0] nxt_left;
  logic [31:0] calc_addr;
  logic [15:0] calc_left;
  logic [7:0]  calc_arlen;
  logic        calc_last;
  logic [7:0]  calc_keep;

  logic        r_acc;
  logic        final_beat;
  logic        beat_err;
  logic        unused_haddr;

  assign desc.addr    = {haddr[31:3], 3'b000};
  assign desc.len     = haddr[47:32];
  assign desc.eof     = haddr[63];
  assign unused_haddr = ^{haddr[62:48], haddr[2:0]};

  // Position after the burst in flight; only meaningful in DATA.
  assign burst_beats = {1'b0, arlen} + 9'd1;
  assign nxt_addr    = cur_addr + {20'd0, burst_beats, 3'b000};
  assign nxt_left    = last_burst_r ? 16'd0 : (bytes_left - {4'd0, burst_beats, 3'b000});

  // The calculator sizes the *next* burst so its AR can be registered on the
  // same edge that leaves POP or finishes the previous burst.
  assign calc_addr = (state == ST_POP) ? desc.addr : nxt_addr;
  assign calc_left = (state == ST_POP) ? desc.len  : nxt_left;

  dma_burst_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .cur_addr   (calc_addr),
    .bytes_left (calc_left),
    .arlen      (calc_arlen),
    .last_burst (calc_last),
    .keep_last  (calc_keep)
  );

  assign arsize  = AXI_SIZE_8B;
  assign arburst = AXI_BURST_INCR;
  assign arid    = AXI_ID;

  // Accept a beat only when the tx register is empty or draining this cycle.
  assign rready     = (state == ST_DATA) && (!tx_valid || tx_ready);
  assign r_acc      = rvalid && rready;
  assign final_beat = last_burst_r && rlast;
  assign beat_err   = r_acc && (rresp != AXI_RESP_OKAY);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clks.clk or negedge clks.rst) begin
    if (!clks.rst) begin
      state        <= ST_IDLE;
      rd_en        <= 1'b0;
      araddr       <= '0;
      arlen        <= '0;
      arvalid      <= 1'b0;
      tx_data      <= '0;
      tx_keep      <= '0;
      tx_last      <= 1'b0;
      tx_valid     <= 1'b0;
      frames_done  <= '0;
      err          <= 1'b0;
      cur_addr     <= '0;
      bytes_left   <= '0;
      eof_r        <= 1'b0;
      last_burst_r <= 1'b0;
      keep_last_r  <= '0;
    end else begin
      rd_en <= 1'b0;

      // Output register stage
      if (r_acc) begin
        tx_valid <= 1'b1;
        tx_data  <= rdata;
        tx_keep  <= final_beat ? keep_last_r : 8'hFF;
        tx_last  <= eof_r && final_beat;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      if (beat_err) begin
        err <= 1'b1;
      end

      // Control stage
      case (state)
        ST_IDLE: begin
          if (enable && !stack_empty) begin
            state <= ST_POP;
            rd_en <= 1'b1;
          end
        end

        ST_POP: begin
          cur_addr    <= calc_addr;
          bytes_left  <= desc.len;
          eof_r       <= desc.eof;
          keep_last_r <= calc_keep;
          if (desc.len == 16'd0) begin
            state <= ST_IDLE;
          end else begin
            state        <= ST_ADDR;
            arvalid      <= 1'b1;
            araddr       <= calc_addr;
            arlen        <= calc_arlen;
            last_burst_r <= calc_last;
          end
        end

        ST_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (r_acc && rlast) begin
            cur_addr   <= nxt_addr;
            bytes_left <= nxt_left;
            if (!last_burst_r) begin
              state        <= ST_ADDR;
              arvalid      <= 1'b1;
              araddr       <= calc_addr;
              arlen        <= calc_arlen;
              last_burst_r <= calc_last;
            end else begin
              if (eof_r) begin
                frames_done <= frames_done + 16'd1;
              end
              // A failing descriptor is always finished before parking.
              state <= (err || beat_err) ? ST_ERR : ST_IDLE;
            end
          end
        end

        ST_ERR: state <= ST_ERR;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_tx_fetch.sv
module tb_dma_tx_fetch;
  import dma_pkg::*;

  localparam int         MAX_BURST = 16;
  localparam logic [3:0] AXI_ID    = 4'h0;

  AXI_clks clks_if();

  logic        enable;
  logic [63:0] haddr;
  logic        stack_empty;
  logic        rd_en;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frames_done;
  logic        err;

  dma_tx_fetch #(.MAX_BURST(MAX_BURST), .AXI_ID(AXI_ID)) dut (
    .clks(clks_if), .enable(enable), .haddr(haddr), .stack_empty(stack_empty),
    .rd_en(rd_en), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frames_done(frames_done), .err(err)
  );

  initial begin
    clks_if.clk = 1'b0;
    forever #5 clks_if.clk = ~clks_if.clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total;
  int bad;

  logic [72:0] exp_tx[$];   // {data, keep, last}
  logic [39:0] exp_ar[$];   // {araddr, arlen}
  logic [63:0] stack_q[$];

  // Slave / environment state
  logic        s_active;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [7:0]  s_idx;
  int          beat_no;
  int          err_at;
  logic        rnd_ready;
  logic        rnd_ar;
  int          ar_viol;
  int          rr_viol;
  int          tx_seen;
  logic        prev_ar_wait;
  logic [39:0] prev_ar;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_desc(input logic [31:0] addr, input logic [15:0] len, input logic eof);
    stack_q.push_back({eof, 15'd0, len, addr});
  endtask

  task automatic expect_beats(input logic [31:0] addr, input logic [15:0] len,
                              input logic eof, input logic [7:0] keep_last);
    logic [31:0] a;
    int n;
    a = {addr[31:3], 3'b000};
    n = (int'(len) + 7) / 8;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back({mem_word(a + 32'(i * 8)),
                        (i == n - 1) ? keep_last : 8'hFF,
                        eof && (i == n - 1)});
    end
  endtask

  // Waits for all expected traffic to drain; the main process works at
  // posedge+2 so it never races the environment, which updates at posedge+1.
  task automatic wait_done(input string name, input int budget, input logic allow_busy);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_ar.size() != 0 || (busy && !allow_busy) ||
            (stack_q.size() != 0 && !allow_busy) || tx_valid) && n < budget) begin
      @(posedge clks_if.clk);
      #2;
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending beats, %0d pending ARs, required 0",
               name, exp_tx.size(), exp_ar.size());
    end
  endtask

  // Environment: descriptor stack, AXI read slave, tx sink and scoreboard.
  initial begin : env
    logic ar_hs, r_hs, tx_hs, rd_hs;
    s_active = 1'b0; s_addr = '0; s_len = '0; s_idx = '0; beat_no = 0;
    ar_viol = 0; rr_viol = 0; tx_seen = 0; prev_ar_wait = 1'b0; prev_ar = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    tx_ready = 1'b1; stack_empty = 1'b1; haddr = '0;
    forever begin
      @(negedge clks_if.clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      tx_hs = tx_valid && tx_ready;
      rd_hs = rd_en;
      if (clks_if.rst) begin
        if (prev_ar_wait && (!arvalid || {araddr, arlen} != prev_ar)) ar_viol++;
        prev_ar_wait = arvalid && !arready;
        prev_ar      = {araddr, arlen};
        if (tx_valid && !tx_ready && rready) rr_viol++;
        if (ar_hs) begin
          if (exp_ar.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_extra: got AR %0h/%0d, required none", araddr, arlen);
          end else begin
            check("ar_fields", {araddr, arlen}, exp_ar.pop_front());
          end
        end
        if (tx_hs) begin
          tx_seen++;
          if (exp_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_extra: got beat %0h, required none", tx_data);
          end else begin
            check("tx_beat", {tx_data, tx_keep, tx_last}, exp_tx.pop_front());
          end
        end
      end
      @(posedge clks_if.clk);
      #1;
      if (!clks_if.rst) begin
        s_active = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        arready = 1'b0; tx_ready = 1'b1; prev_ar_wait = 1'b0;
      end else begin
        if (rd_hs && stack_q.size() > 0) void'(stack_q.pop_front());
        if (r_hs) begin
          beat_no++;
          if (rlast) s_active = 1'b0;
          else s_idx = s_idx + 8'd1;
        end
        if (ar_hs) begin
          s_active = 1'b1; s_addr = araddr; s_len = arlen; s_idx = 8'd0;
        end
        rvalid   = s_active;
        rdata    = mem_word(s_addr + {21'd0, s_idx, 3'b000});
        rlast    = s_active && (s_idx == s_len);
        rresp    = (s_active && beat_no == err_at) ? 2'b10 : 2'b00;
        arready  = rnd_ar ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      stack_empty = (stack_q.size() == 0);
      haddr       = stack_empty ? 64'd0 : stack_q[0];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        eof;
    logic        rnd;
    int          n_ar;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    logic [7:0]  keep_last;
  } case_t;

  case_t tbl[5];
  int    exp_frames;
  int    seen0;

  initial begin : main
    total = 0; bad = 0; exp_frames = 0; seen0 = 0;
    enable = 1'b0; rnd_ready = 1'b0; rnd_ar = 1'b0; err_at = -1;
    clks_if.rst = 1'b0;

    tbl[0] = '{32'h0000_1000, 16'd20,  1'b1, 1'b0, 1, 32'h0000_1000, 8'd2,  32'h0, 8'd0, 8'h0F};
    tbl[1] = '{32'h0000_2000, 16'd200, 1'b1, 1'b0, 2, 32'h0000_2000, 8'd15, 32'h0000_2080, 8'd8, 8'hFF};
    tbl[2] = '{32'h0000_3000, 16'd64,  1'b1, 1'b1, 1, 32'h0000_3000, 8'd7,  32'h0, 8'd0, 8'hFF};
    tbl[3] = '{32'h0000_4009, 16'd13,  1'b0, 1'b1, 1, 32'h0000_4008, 8'd1,  32'h0, 8'd0, 8'h1F};
`ifdef DMA_TX_4K_SPLIT_EN
    tbl[4] = '{32'h0000_0FC0, 16'd128, 1'b1, 1'b0, 2, 32'h0000_0FC0, 8'd7,  32'h0000_1000, 8'd7, 8'hFF};
`else
    tbl[4] = '{32'h0000_0FC0, 16'd128, 1'b1, 1'b0, 1, 32'h0000_0FC0, 8'd15, 32'h0, 8'd0, 8'hFF};
`endif

    // Reset values
    repeat (3) @(posedge clks_if.clk);
    #2;
    check("rst_rd_en", rd_en, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_keep", tx_keep, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_arsize", arsize, 3'b011);
    check("rst_arburst", arburst, AXI_BURST_INCR);
    check("rst_arid", arid, AXI_ID);
    clks_if.rst = 1'b1;
    enable = 1'b1;

    // Table-driven descriptors
    for (int k = 0; k < 5; k++) begin
      rnd_ready = tbl[k].rnd;
      rnd_ar    = tbl[k].rnd;
      exp_ar.push_back({tbl[k].a0, tbl[k].l0});
      if (tbl[k].n_ar > 1) exp_ar.push_back({tbl[k].a1, tbl[k].l1});
      expect_beats(tbl[k].addr, tbl[k].len, tbl[k].eof, tbl[k].keep_last);
      if (tbl[k].eof) exp_frames++;
      @(posedge clks_if.clk);
      #2;
      push_desc(tbl[k].addr, tbl[k].len, tbl[k].eof);
      if (k == 0) begin
        // stack_empty falls at the next posedge+1; arvalid two edges later.
        @(posedge clks_if.clk);
        #2;
        check("stack_visible", stack_empty, 0);
        repeat (2) @(posedge clks_if.clk);
        #2;
        check("ar_latency", arvalid, 1);
      end
      wait_done($sformatf("case%0d", k), 2000, 1'b0);
      check($sformatf("case%0d_frames", k), frames_done, exp_frames);
      check($sformatf("case%0d_err", k), err, 0);
    end
    rnd_ready = 1'b0;
    rnd_ar    = 1'b0;

    // Zero-length descriptor followed by a one-word EOF frame
    seen0 = tx_seen;
    exp_ar.push_back({32'h0000_7100, 8'd0});
    expect_beats(32'h0000_7100, 16'd8, 1'b1, 8'hFF);
    exp_frames++;
    push_desc(32'h0000_7000, 16'd0, 1'b1);
    push_desc(32'h0000_7100, 16'd8, 1'b1);
    wait_done("len0_len8", 500, 1'b0);
    check("len0_len8_frames", frames_done, exp_frames);
    check("len0_len8_beats", tx_seen - seen0, 1);

    // Reset in the middle of a burst
    seen0 = tx_seen;
    exp_ar.push_back({32'h0000_6000, 8'd15});
    expect_beats(32'h0000_6000, 16'd200, 1'b1, 8'hFF);
    push_desc(32'h0000_6000, 16'd200, 1'b1);
    for (int n = 0; n < 300 && (tx_seen - seen0) < 4; n++) begin
      @(posedge clks_if.clk);
      #2;
    end
    check("midrst_started", (tx_seen - seen0) >= 4, 1);
    @(negedge clks_if.clk);
    #2;
    clks_if.rst = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frames", frames_done, 0);
    stack_q.delete();
    exp_tx.delete();
    exp_ar.delete();
    exp_frames = 0;
    repeat (2) @(posedge clks_if.clk);
    #2;
    clks_if.rst = 1'b1;
    @(posedge clks_if.clk);
    #2;
    check("midrst_idle_after", busy, 0);

    // SLVERR on beat 2 of 4, second descriptor waiting on the stack
    err_at = beat_no + 1;
    exp_ar.push_back({32'h0000_5000, 8'd3});
    expect_beats(32'h0000_5000, 16'd32, 1'b1, 8'hFF);
    push_desc(32'h0000_5000, 16'd32, 1'b1);
    push_desc(32'h0000_5100, 16'd8, 1'b1);
    wait_done("slverr", 500, 1'b1);
    repeat (20) @(posedge clks_if.clk);
    #2;
    check("slverr_err", err, 1);
    check("slverr_parked", busy, 1);
    check("slverr_no_pop", stack_q.size(), 1);
    check("slverr_no_ar", arvalid, 0);
    err_at = -1;

    // Reset clears the sticky error
    clks_if.rst = 1'b0;
    stack_q.delete();
    repeat (2) @(posedge clks_if.clk);
    #2;
    check("final_err_cleared", err, 0);
    check("final_busy", busy, 0);
    clks_if.rst = 1'b1;

    check("ar_hold_stable", ar_viol, 0);
    check("rready_backpressure", rr_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
